// File: rtl/softmax_decide.sv
// softmax_decide: winner/confidence decision on a pair of float32 class
// probabilities, queued in a small FIFO with per-class statistics.
module softmax_decide #(
  parameter logic [31:0] THRESH = 32'h3F333333,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [31:0]      prob0,
  input  logic [31:0]      prob1,
  input  logic             out_ready,
  input  logic             clear_stats,
  output logic             out_valid,
  output logic             out_class,
  output logic [31:0]      out_conf,
  output logic             out_low,
  output logic             out_err,
  output logic             overflow,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef struct packed {
    logic        cls;
    logic [31:0] conf;
    logic        low;
    logic        err;
  } dec_t;

  // Stage-1 registers
  logic        r_s1_valid;
  logic [31:0] r_p0;
  logic [31:0] r_p1;

  // FIFO state
  dec_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [OCC_W-1:0] r_count;

  // Registered head presentation and statistics
  logic             r_out_valid;
  dec_t             r_head;
  logic             r_overflow;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic [CNT_W-1:0] r_drop;

  // Stage-2 combinational decision
  logic             w_inv;
  logic             w_cls;
  dec_t             w_dec;

  // FIFO control
  logic             w_pop;
  logic             w_full;
  logic             w_push_ok;
  logic             w_drop;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [OCC_W-1:0] w_occ_after_pop;
  logic [OCC_W-1:0] w_count_nxt;
  dec_t             w_head_nxt;

  // Saturating increment for statistics counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage 1: capture the probability pair on valid_in
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_p0       <= '0;
      r_p1       <= '0;
    end else begin
      r_s1_valid <= valid_in;
      if (valid_in) begin
        r_p0 <= prob0;
        r_p1 <= prob1;
      end
    end
  end

  // Stage 2: validity, winner selection on magnitude bits, threshold compare
  always_comb begin
    w_inv = r_p0[31] | (r_p0[30:23] == 8'hFF) |
            r_p1[31] | (r_p1[30:23] == 8'hFF);
    // Ties resolve to class 0, so class 1 wins only on strictly greater
    w_cls = (r_p1[30:0] > r_p0[30:0]);
    w_dec = '0;
    if (w_inv) begin
      w_dec.err  = 1'b1;
      w_dec.cls  = 1'b0;
      w_dec.conf = 32'h0;
      w_dec.low  = 1'b1;
    end else begin
      w_dec.err  = 1'b0;
      w_dec.cls  = w_cls;
      w_dec.conf = w_cls ? r_p1 : r_p0;
      w_dec.low  = (w_dec.conf[30:0] < THRESH[30:0]);
    end
  end

  // FIFO push/pop arbitration and next head selection
  always_comb begin
    w_pop           = r_out_valid & out_ready;
    w_full          = (r_count == OCC_W'(DEPTH));
    w_push_ok       = r_s1_valid & (~w_full | w_pop);
    w_drop          = r_s1_valid & w_full & ~w_pop;
    w_rd_nxt        = w_pop ? r_rd + PTR_W'(1) : r_rd;
    w_occ_after_pop = r_count - OCC_W'(w_pop);
    w_count_nxt     = w_occ_after_pop + OCC_W'(w_push_ok);
    w_head_nxt      = r_head;
    // An entry written into an otherwise-empty queue becomes the head directly
    if (w_push_ok && (w_occ_after_pop == '0)) begin
      w_head_nxt = w_dec;
    end else if (w_occ_after_pop != '0) begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // FIFO storage, pointers and registered head
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr] <= w_dec;
        r_wr        <= r_wr + PTR_W'(1);
      end
      r_rd        <= w_rd_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
      r_head      <= w_head_nxt;
    end
  end

  // Statistics: class counters, drop counter and sticky overflow; clear wins
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      r_cnt0     <= '0;
      r_cnt1     <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_s1_valid && !w_inv && !w_cls) r_cnt0 <= sat_inc(r_cnt0);
      if (r_s1_valid && !w_inv &&  w_cls) r_cnt1 <= sat_inc(r_cnt1);
      if (w_drop) begin
        r_drop     <= sat_inc(r_drop);
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_class = r_head.cls;
  assign out_conf  = r_head.conf;
  assign out_low   = r_head.low;
  assign out_err   = r_head.err;
  assign overflow  = r_overflow;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_softmax_decide.sv
// Directed bench for softmax_decide with hand-computed expectations.
module tb_softmax_decide;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             valid_in;
  logic [31:0]      prob0;
  logic [31:0]      prob1;
  logic             out_ready;
  logic             clear_stats;
  logic             out_valid;
  logic             out_class;
  logic [31:0]      out_conf;
  logic             out_low;
  logic             out_err;
  logic             overflow;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  softmax_decide #(
    .THRESH (32'h3F333333),
    .DEPTH  (4),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .prob0       (prob0),
    .prob1       (prob1),
    .out_ready   (out_ready),
    .clear_stats (clear_stats),
    .out_valid   (out_valid),
    .out_class   (out_class),
    .out_conf    (out_conf),
    .out_low     (out_low),
    .out_err     (out_err),
    .overflow    (overflow),
    .cnt0        (cnt0),
    .cnt1        (cnt1),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle valid pulse; returns after the stage-1 load edge
  task automatic send(input logic [31:0] p0, input logic [31:0] p1);
    valid_in = 1'b1;
    prob0    = p0;
    prob1    = p1;
    tick();
    valid_in = 1'b0;
  endtask

  // Pulse, then wait for the FIFO write edge so the head is visible
  task automatic decide(input logic [31:0] p0, input logic [31:0] p1);
    send(p0, p1);
    tick();
  endtask

  task automatic chk_head(input string tag, input logic cls, input logic [31:0] conf,
                          input logic low, input logic err);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".class"}, 32'(out_class), 32'(cls));
    chk({tag, ".conf"},  out_conf, conf);
    chk({tag, ".low"},   32'(out_low), 32'(low));
    chk({tag, ".err"},   32'(out_err), 32'(err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".class"}, 32'(out_class), 32'd0);
    chk({tag, ".conf"},  out_conf, 32'd0);
    chk({tag, ".low"},   32'(out_low), 32'd0);
    chk({tag, ".err"},   32'(out_err), 32'd0);
    chk({tag, ".ovf"},   32'(overflow), 32'd0);
    chk({tag, ".cnt0"},  32'(cnt0), 32'd0);
    chk({tag, ".cnt1"},  32'(cnt1), 32'd0);
    chk({tag, ".drop"},  32'(drop_cnt), 32'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_q [4];
    int n;

    reset       = 1'b1;
    valid_in    = 1'b0;
    prob0       = '0;
    prob1       = '0;
    out_ready   = 1'b0;
    clear_stats = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;

    // Basic decision: 0.8 vs 0.2
    out_ready = 1'b1;
    decide(32'h3F4CCCCD, 32'h3E4CCCCD);
    chk_head("basic", 1'b0, 32'h3F4CCCCD, 1'b0, 1'b0);
    chk("basic.cnt0", 32'(cnt0), 32'd1);
    chk("basic.cnt1", 32'(cnt1), 32'd0);
    tick();
    chk("basic.drained", 32'(out_valid), 32'd0);

    // Winner exactly at threshold is not low
    decide(32'h3E99999A, 32'h3F333333);
    chk_head("thresh", 1'b1, 32'h3F333333, 1'b0, 1'b0);
    chk("thresh.cnt1", 32'(cnt1), 32'd1);
    tick();

    // Tie goes to class 0; 0.5 is below threshold
    decide(32'h3F000000, 32'h3F000000);
    chk_head("tie", 1'b0, 32'h3F000000, 1'b1, 1'b0);
    chk("tie.cnt0", 32'(cnt0), 32'd2);
    tick();

    // NaN on prob0
    decide(32'h7FC00000, 32'h3E000000);
    chk_head("nan", 1'b0, 32'h0, 1'b1, 1'b1);
    chk("nan.cnt0", 32'(cnt0), 32'd2);
    chk("nan.cnt1", 32'(cnt1), 32'd1);
    tick();

    // Negative prob1
    decide(32'h3F000000, 32'hBF800000);
    chk_head("neg", 1'b0, 32'h0, 1'b1, 1'b1);
    chk("neg.cnt0", 32'(cnt0), 32'd2);
    chk("neg.cnt1", 32'(cnt1), 32'd1);
    tick();

    // +Inf on prob1
    decide(32'h3E000000, 32'h7F800000);
    chk_head("inf", 1'b0, 32'h0, 1'b1, 1'b1);
    chk("inf.cnt1", 32'(cnt1), 32'd1);
    tick();
    chk("inf.drained", 32'(out_valid), 32'd0);

    // Backpressure: 5 class-1 winners into a 4-deep FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      prob0    = 32'h3E800000;
      prob1    = 32'h3F400000 + 32'(i);
      tick();
    end
    valid_in = 1'b0;
    tick();
    chk("bp.ovf",  32'(overflow), 32'd1);
    chk("bp.drop", 32'(drop_cnt), 32'd1);
    chk("bp.cnt1", 32'(cnt1), 32'd6);
    chk_head("bp.hold", 1'b1, 32'h3F400000, 1'b0, 1'b0);
    tick();
    chk("bp.stable", out_conf, 32'h3F400000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("bp.pop%0d", i), 1'b1, 32'h3F400000 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Full FIFO with push and pop in the same edge
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      prob0    = 32'h3E800000;
      prob1    = 32'h3F400010 + 32'(i);
      tick();
    end
    valid_in = 1'b0;
    tick();
    send(32'h3E800000, 32'h3F400020);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fpp.drop", 32'(drop_cnt), 32'd1);
    chk("fpp.cnt1", 32'(cnt1), 32'd11);
    chk_head("fpp.head", 1'b1, 32'h3F400011, 1'b0, 1'b0);
    exp_q[0] = 32'h3F400011;
    exp_q[1] = 32'h3F400012;
    exp_q[2] = 32'h3F400013;
    exp_q[3] = 32'h3F400020;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 8) begin
      if (n < 4) chk($sformatf("fpp.pop%0d", n), out_conf, exp_q[n]);
      n++;
      tick();
    end
    chk("fpp.occupancy", 32'(n), 32'd4);

    // Reset with 3 entries queued and stage 1 busy
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      prob0    = 32'h3F4CCCCD;
      prob1    = 32'h3E4CCCCD;
      tick();
    end
    valid_in = 1'b0;
    chk("rst.pre_cnt0", 32'(cnt0), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("rst");
    tick();
    chk("rst.inflight_gone", 32'(out_valid), 32'd0);
    chk("rst.cnt0_stays", 32'(cnt0), 32'd0);
    out_ready = 1'b1;
    decide(32'h3F4CCCCD, 32'h3E4CCCCD);
    chk_head("post_rst", 1'b0, 32'h3F4CCCCD, 1'b0, 1'b0);
    chk("post_rst.cnt0", 32'(cnt0), 32'd1);
    tick();

    // clear_stats on the same edge as a class-0 increment
    send(32'h3F4CCCCD, 32'h3E4CCCCD);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clr.cnt0", 32'(cnt0), 32'd0);
    chk("clr.cnt1", 32'(cnt1), 32'd0);
    chk_head("clr.head", 1'b0, 32'h3F4CCCCD, 1'b0, 1'b0);
    tick();
    chk("clr.drained", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/softmax_decide.md
# softmax_decide

Decision stage on the probability output of the 2-class softmax. Each valid pulse carries two IEEE-754 single-precision probabilities. The block picks the winning class and checks the winning probability against a confidence threshold. It flags malformed inputs, queues decisions in a small FIFO drained through a ready/valid handshake, and keeps per-class statistics counters. It is fully synthesizable: floating-point comparison is done on raw bit patterns, with no real arithmetic.

## Interface
- THRESH, 32'h3F333333 (0.7): float32 confidence threshold; must be non-negative and finite.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CNT_W, 16: width of the statistics counters.

Ports (name, direction, width, meaning):
- clk: input, 1. Single clock, rising edge.
- reset: input, 1. Synchronous, active-high reset.
- valid_in: input, 1. One-cycle pulse; prob0/prob1 are valid in that cycle.
- prob0: input, 32. Float32 probability of class 0.
- prob1: input, 32. Float32 probability of class 1.
- out_ready: input, 1. Downstream can accept a decision.
- clear_stats: input, 1. Synchronous clear of cnt0, cnt1, drop_cnt and overflow.
- out_valid: output, 1. FIFO is non-empty.
- out_class: output, 1. Winning class of the head entry.
- out_conf: output, 32. Winning probability (float32 bits) of the head entry.
- out_low: output, 1. Head entry's out_conf is below THRESH.
- out_err: output, 1. Head entry's input was invalid.
- overflow: output, 1. Sticky: a decision was dropped because the FIFO was full.
- cnt0: output, CNT_W. Count of class-0 decisions.
- cnt1: output, CNT_W. Count of class-1 decisions.
- drop_cnt: output, CNT_W. Count of dropped decisions.

## Operation
- Stage 1: on valid_in, register prob0, prob1 and a stage-1 valid bit. With valid_in low, the stage-1 valid bit clears; the data registers hold their values.
- Stage 2 runs combinationally on the stage-1 registers; the result is pushed into the FIFO at the next edge.
  - Invalid input: either operand has sign=1, or exp=8'hFF (Inf or NaN). Output is err=1, class=0, conf=32'h0, low=1. Neither class counter moves.
  - Otherwise, compare bits[30:0] as unsigned integers; this is valid for non-negative floats. The larger value wins; a tie resolves to class 0. conf is the winner's 32-bit pattern.
  - low = (conf[30:0] < THRESH[30:0]). Equal to the threshold counts as not low.
  - Valid decisions increment cnt0 or cnt1 according to class, even when the push is dropped. Counters saturate at all-ones and do not wrap.
- FIFO: circular buffer of DEPTH entries {class, conf, low, err}, with read/write pointers and an occupancy count.
  - push = stage-1 valid; pop = out_valid & out_ready.
  - Full with push and no pop: the entry is dropped, overflow sets, and drop_cnt increments (saturating).
  - Full with push and pop in the same cycle: both happen and nothing is dropped.
  - Empty with push: out_valid rises the following cycle; there is no combinational fall-through.
  - Output fields reflect the head entry. They hold stable while out_valid=1 and out_ready=0.
- clear_stats in the same cycle as an increment: the clear wins and the counter becomes 0.
- reset: all state clears on the next edge, including mid-stream. In-flight stage-1 data and FIFO contents are discarded. out_valid=0, out_class=0, out_conf=0, out_low=0, out_err=0, overflow=0, cnt0=cnt1=drop_cnt=0.

## Timing
- valid_in sampled at edge t. The stage-1 register loads at t; the FIFO write happens at edge t+1.
- With the FIFO empty, out_valid is high in the cycle after edge t+1. Latency is 2 clocks.
- Throughput: one decision per clock sustained when out_ready=1.
- Counter updates land at the same edge as the FIFO write, i.e. t+1.
- A pop retires the head at the edge where out_valid & out_ready is sampled high. The next entry is presented in the following cycle.
- No output depends combinationally on out_ready or valid_in.

## Test plan
- Basic decision: prob0=3F4CCCCD (0.8), prob1=3E4CCCCD (0.2), out_ready=1. Expect out_valid 2 clocks later with class=0, conf=3F4CCCCD, low=0, err=0, and cnt0=1.
- Threshold and tie: (3E99999A, 3F333333) gives class=1, low=0 (equal to threshold), cnt1=1. (3F000000, 3F000000) gives class=0, conf=3F000000, low=1.
- Invalid inputs: prob0=7FC00000 (NaN) gives err=1, class=0, conf=0, low=1, with cnt0 and cnt1 unchanged. prob1=BF800000 (negative) likewise gives err=1.
- Backpressure and overflow: out_ready=0, 5 back-to-back valid_in with class-1 winners. Expect 4 entries held, overflow=1, drop_cnt=1, cnt1=5. Then raise out_ready and expect 4 pops in order, after which out_valid=0.
- Full with simultaneous push and pop: FIFO full, out_ready=1, one more valid_in. Expect no drop (drop_cnt unchanged) and occupancy to stay at 4 for that cycle.
- Reset mid-stream and clear_stats: with 3 entries queued and stage 1 busy, assert reset for 1 cycle. Expect out_valid=0 and all counters 0 next cycle; stimulus after reset behaves as in the basic-decision test. Assert clear_stats together with an incoming valid decision and expect cnt0=0.
